ctu_clsp_relock_ctl: RTL and testbench
======================================

// Module: ctu_clsp_relock_ctl
// PURPOSE
//  Scheduler for PLL relock events in the CTU reference-clock domain. Arbitrates frequency-change,
//  warm-reset and tester-reset requesters, then drives the relock strobes into the PLL lock counter.
//  Sequences each event through lock drop and lock return, then acknowledges the requester.
//  Latches the new PLL divider for frequency changes. Sits between CTU reset/CSR logic and ctu_clsp_pllcnt.
// PARAMETERS
//  PULSE_W    4        cycles a relock strobe is held high (pllcnt edge-detects; >=2)
//  UNLOCK_TMO 16'h00FF max cycles from strobe end to pll_locked_ref falling
//  LOCK_TMO   16'hFFFF max cycles from lock drop to pll_locked_ref rising
//  GAP_CNT    8        idle cycles enforced between consecutive events
//  DIV_W      6        width of PLL divider config
//  DIV_RST    6'd4     reset value of pll_div_cfg
// PORTS
//  pll_raw_clk_out in  1     reference clock
//  rst_ref         in  1     synchronous reset, active high
//  pll_locked_ref  in  1     PLL-locked state from lock counter
//  fc_req          in  1     frequency-change request (level, held until fc_ack)
//  fc_div          in  DIV_W divider for fc_req, stable while fc_req high
//  wrm_req         in  1     warm-reset relock request (level)
//  tst_req         in  1     tester-reset relock request (level)
//  fc_ack/wrm_ack/tst_ack out 1 one-cycle completion pulse per requester
//  wrm_rst_fc_ref  out 1     freq-change relock strobe to pllcnt
//  wrm_rst_ref     out 1     warm-reset relock strobe
//  tst_rst_ref     out 1     tester-reset relock strobe
//  pll_div_cfg     out DIV_W divider applied to PLL
//  busy            out 1     high in any state except IDLE
//  tmo_err         out 1     sticky timeout flag
// BEHAVIOUR
//  Reset (rst_ref=1 at edge): state IDLE; all strobes, acks, busy, tmo_err =0; pll_div_cfg=DIV_RST; counters 0.
//  Reset mid-event: strobes drop next edge, no ack issued; requester must re-request.
//  States: IDLE -> STRB -> WUNLK -> WLCK -> ACK -> GAP -> IDLE.
//  IDLE: if pll_locked_ref & any req: grant fixed priority fc > wrm > tst; one-hot grant register loaded;
//        if fc granted, pll_div_cfg <= fc_div same edge. Not locked -> requests wait, no timeout.
//  STRB: granted strobe high exactly PULSE_W cycles; first high cycle = 1 cycle after grant edge.
//  WUNLK: wait pll_locked_ref=0. Exit next edge after it falls.
//  WLCK: wait pll_locked_ref=1, then ACK.
//  ACK: granted *_ack high exactly 1 cycle; grant cleared.
//  GAP: GAP_CNT cycles, requests ignored; a req still high after GAP is a new event.
//  Requesters must drop req the cycle after ack; req dropped before ack does not abort the event.
//  Simultaneous requests: losers stay pending, served in later events in priority order.
//  Only one strobe ever high; busy=1 in STRB..GAP.
//  Counters: one shared 16-bit down-counter, reloaded at each state entry; no wrap (saturates at 0).
// CONFIGURATION
//  CTU_RELOCK_TMO_EN defined: WUNLK exits after UNLOCK_TMO cycles, WLCK after LOCK_TMO cycles
//    without the expected edge. Exit goes to ACK (ack still issued) and sets tmo_err (sticky until rst_ref).
//  Not defined: WUNLK/WLCK wait indefinitely; tmo_err tied 0; timeout parameters unused.
// STRUCTURE
//  ctu.h: one-hot state bit indices and encodings (RLSM_* / ST_RLSM_*), grant index defines.
//  Sub-module ctu_clsp_dcnt: loadable 16-bit down-counter, inputs ld/val/en, output dn when count==0.
//    Shared by STRB width, timeout and GAP counting.
//  Top: state machine, grant register, divider register, output flops (all outputs registered).
// TESTING
//  1. Locked, fc_req=1, fc_div=6'd9:
//     pll_div_cfg=9 at grant; wrm_rst_fc_ref high 4 cycles; lock drop/return; fc_ack 1 cycle; busy low after 8 GAP cycles.
//  2. fc_req, wrm_req, tst_req rise same cycle: served fc, wrm, tst in that order.
//     Each separated by >=8 idle cycles; never two strobes high together.
//  3. pll_locked_ref=0, wrm_req=1 for 1000 cycles: no strobe.
//     Lock rises -> wrm_rst_ref asserted next cycle.
//  4. CTU_RELOCK_TMO_EN, tst event, lock never drops:
//     after 255 cycles tst_ack pulses, tmo_err=1 and stays 1 until rst_ref.
//  5. rst_ref during WLCK: next cycle state IDLE, busy=0, no ack, pll_div_cfg=4.
//  6. Without CTU_RELOCK_TMO_EN, lock withheld 70000 cycles: stays WLCK, tmo_err=0; ack after lock rises.

Source files
------------

// File: rtl/ctu_clsp_relock_ctl_pkg.sv
// ctu_clsp_relock_ctl_pkg: shared state encodings, grant indices and the grant arbiter
// for the PLL relock scheduler.
// Contents: rlsm_e (one-hot state encoding), GNT_* (bit positions in the grant vector),
// pick() (fixed-priority arbiter).
package ctu_clsp_relock_ctl_pkg;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_STRB  = 6'b000010,
        ST_WUNLK = 6'b000100,
        ST_WLCK  = 6'b001000,
        ST_ACK   = 6'b010000,
        ST_GAP   = 6'b100000
    } rlsm_e;

    // Bit positions in the grant vector. The strobe and ack outputs are packed in the same order.
    localparam int GNT_FC  = 0;
    localparam int GNT_WRM = 1;
    localparam int GNT_TST = 2;

    // Fixed priority: frequency change, then warm reset, then tester reset.
    function automatic logic [2:0] pick(input logic fc, input logic wrm, input logic tst);
        return fc ? 3'b001 : wrm ? 3'b010 : tst ? 3'b100 : 3'b000;
    endfunction

endpackage

// File: rtl/ctu_clsp_relock_ctl_dcnt.sv
// ctu_clsp_relock_ctl_dcnt: loadable 16-bit down-counter that saturates at zero.
// Ports: clk, rst (sync, active high), ld/val (load value), en (count enable),
// dn (high while count == 0).
module ctu_clsp_relock_ctl_dcnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic [15:0] val,
    input  logic        en,
    output logic        dn
);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (ld)
            cnt <= val;
        else if (en && cnt != 16'd0)
            cnt <= cnt - 16'd1;
    end

    assign dn = cnt == 16'd0;

endmodule

// File: rtl/ctu_clsp_relock_ctl.sv
// ctu_clsp_relock_ctl: arbitrates frequency-change, warm-reset and tester-reset relock requests,
// drives one relock strobe into the PLL lock counter, waits for the lock to drop and return,
// acknowledges the requester, then enforces an idle gap before the next event.
// Ports: pll_raw_clk_out (clock), rst_ref (sync active-high reset), pll_locked_ref,
// fc_req/fc_div, wrm_req, tst_req in; fc_ack/wrm_ack/tst_ack, wrm_rst_fc_ref/wrm_rst_ref/tst_rst_ref,
// pll_div_cfg, busy, tmo_err out. All outputs are registered.
// Optional feature: define CTU_RELOCK_TMO_EN to bound the unlock/lock waits with timeouts
// that set the sticky tmo_err flag; otherwise the waits are unbounded and tmo_err is 0.
module ctu_clsp_relock_ctl
    import ctu_clsp_relock_ctl_pkg::*;
#(
    parameter int          PULSE_W    = 4,
    parameter logic [15:0] UNLOCK_TMO = 16'h00FF,
    parameter logic [15:0] LOCK_TMO   = 16'hFFFF,
    parameter int          GAP_CNT    = 8,
    parameter int          DIV_W      = 6,
    parameter logic [DIV_W-1:0] DIV_RST = DIV_W'(4)
) (
    input  logic             pll_raw_clk_out,
    input  logic             rst_ref,
    input  logic             pll_locked_ref,
    input  logic             fc_req,
    input  logic [DIV_W-1:0] fc_div,
    input  logic             wrm_req,
    input  logic             tst_req,
    output logic             fc_ack,
    output logic             wrm_ack,
    output logic             tst_ack,
    output logic             wrm_rst_fc_ref,
    output logic             wrm_rst_ref,
    output logic             tst_rst_ref,
    output logic [DIV_W-1:0] pll_div_cfg,
    output logic             busy,
    output logic             tmo_err
);

    rlsm_e       state, state_nxt;
    logic [2:0]  gnt, gnt_nxt;
    logic        cnt_ld, cnt_dn, tmo_hit;
    logic [15:0] cnt_val;

`ifdef CTU_RELOCK_TMO_EN
    // The shared counter reaching zero while still waiting for the expected lock edge is a timeout.
    assign tmo_hit = cnt_dn && ((state == ST_WUNLK && pll_locked_ref) ||
                                (state == ST_WLCK && !pll_locked_ref));
    always_ff @(posedge pll_raw_clk_out) begin
        if (rst_ref)
            tmo_err <= 1'b0;
        else
            tmo_err <= tmo_err | tmo_hit;
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        case (state)
            ST_IDLE: begin
                if (pll_locked_ref && (fc_req || wrm_req || tst_req)) begin
                    state_nxt = ST_STRB;
                    gnt_nxt   = pick(fc_req, wrm_req, tst_req);
                end
            end
            ST_STRB:  state_nxt = cnt_dn ? ST_WUNLK : ST_STRB;
            ST_WUNLK: state_nxt = !pll_locked_ref ? ST_WLCK : tmo_hit ? ST_ACK : ST_WUNLK;
            ST_WLCK:  state_nxt = (pll_locked_ref || tmo_hit) ? ST_ACK : ST_WLCK;
            ST_ACK: begin
                state_nxt = ST_GAP;
                gnt_nxt   = '0;
            end
            ST_GAP:   state_nxt = cnt_dn ? ST_IDLE : ST_GAP;
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // The counter is reloaded on every state change with the length of the state being entered,
    // so a load of N-1 gives exactly N cycles in that state before dn is seen.
    assign cnt_ld  = state_nxt != state;
    assign cnt_val = state_nxt == ST_STRB  ? 16'(PULSE_W - 1) :
                     state_nxt == ST_WUNLK ? UNLOCK_TMO - 16'd1 :
                     state_nxt == ST_WLCK  ? LOCK_TMO - 16'd1 :
                     state_nxt == ST_GAP   ? 16'(GAP_CNT - 1) : 16'd0;

    ctu_clsp_relock_ctl_dcnt u_dcnt (
        .clk (pll_raw_clk_out),
        .rst (rst_ref),
        .ld  (cnt_ld),
        .val (cnt_val),
        .en  (state != ST_IDLE),
        .dn  (cnt_dn)
    );

    // Outputs are decoded from the next state so that each registered output is high
    // exactly while the FSM occupies the corresponding state.
    always_ff @(posedge pll_raw_clk_out) begin
        if (rst_ref) begin
            state                                     <= ST_IDLE;
            gnt                                       <= '0;
            pll_div_cfg                               <= DIV_RST;
            {tst_rst_ref, wrm_rst_ref, wrm_rst_fc_ref} <= '0;
            {tst_ack, wrm_ack, fc_ack}                <= '0;
            busy                                      <= 1'b0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            if (state == ST_IDLE && gnt_nxt[GNT_FC])
                pll_div_cfg <= fc_div;
            {tst_rst_ref, wrm_rst_ref, wrm_rst_fc_ref} <= state_nxt == ST_STRB ? gnt_nxt : 3'b000;
            {tst_ack, wrm_ack, fc_ack}                <= state_nxt == ST_ACK ? gnt_nxt : 3'b000;
            busy                                      <= state_nxt != ST_IDLE;
        end
    end

endmodule

// File: tb/tb_ctu_clsp_relock_ctl.sv
// tb_ctu_clsp_relock_ctl: randomized scoreboard bench for ctu_clsp_relock_ctl with a behavioural PLL lock model.
module tb_ctu_clsp_relock_ctl;

    localparam int PULSE_W = 4;
    localparam int GAP_CNT = 8;

    logic       clk = 1'b0, rst_ref = 1'b1, pll_lock = 1'b1, force_unlock = 1'b0;
    logic       fc_req = 1'b0, wrm_req = 1'b0, tst_req = 1'b0;
    logic [5:0] fc_div = 6'd0;
    logic       pll_locked_ref;
    logic       fc_ack, wrm_ack, tst_ack, wrm_rst_fc_ref, wrm_rst_ref, tst_rst_ref, busy, tmo_err;
    logic [5:0] pll_div_cfg;

    assign pll_locked_ref = pll_lock & ~force_unlock;

    ctu_clsp_relock_ctl dut (
        .pll_raw_clk_out (clk),
        .rst_ref         (rst_ref),
        .pll_locked_ref  (pll_locked_ref),
        .fc_req          (fc_req),
        .fc_div          (fc_div),
        .wrm_req         (wrm_req),
        .tst_req         (tst_req),
        .fc_ack          (fc_ack),
        .wrm_ack         (wrm_ack),
        .tst_ack         (tst_ack),
        .wrm_rst_fc_ref  (wrm_rst_fc_ref),
        .wrm_rst_ref     (wrm_rst_ref),
        .tst_rst_ref     (tst_rst_ref),
        .pll_div_cfg     (pll_div_cfg),
        .busy            (busy),
        .tmo_err         (tmo_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] who;
        logic [5:0] div;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         tests = 0, fails = 0, acks_seen = 0, strobe_cycles = 0, lock_hold = 0;
    int         srun = 0, gap = 0, pk = 0;
    logic       in_gap = 1'b0, no_drop = 1'b0, exp_tmo = 1'b0;
    logic [2:0] sv, av, prev_sv = 3'b000;
    logic [5:0] cur_div = 6'd4;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic exp_t mk(input logic [2:0] who, input logic [5:0] div);
        exp_t r;
        r.who = who;
        r.div = div;
        return r;
    endfunction

    // Reference model: simultaneous requests are served in priority order; only a frequency
    // change updates the divider, and later events report whatever divider is current.
    task automatic issue(input logic [2:0] m, input logic [5:0] d);
        if (m[0]) begin
            cur_div = d;
            q.push_back(mk(3'b001, d));
        end
        if (m[1]) q.push_back(mk(3'b010, cur_div));
        if (m[2]) q.push_back(mk(3'b100, cur_div));
        fc_div  = d;
        fc_req  = m[0];
        wrm_req = m[1];
        tst_req = m[2];
    endtask

    // Requester behaviour: drop each request right after its ack; return once all work is done.
    task automatic serve(input int budget);
        int n = 0;
        while ((q.size() != 0 || busy || fc_req || wrm_req || tst_req) && n < budget) begin
            @(negedge clk);
            n++;
            if (fc_ack) fc_req = 1'b0;
            if (wrm_ack) wrm_req = 1'b0;
            if (tst_ack) tst_req = 1'b0;
        end
        if (n >= budget) begin
            tests++;
            fails++;
            $display("FAIL serve_timeout: still busy after %0d cycles, %0d acks outstanding", n, q.size());
        end
    endtask

    // PLL lock model: after a relock strobe ends, lock drops after a short delay and returns later.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_ref && {tst_rst_ref, wrm_rst_ref, wrm_rst_fc_ref} != 3'b000) begin
                pk = 0;
                while ({tst_rst_ref, wrm_rst_ref, wrm_rst_fc_ref} != 3'b000 && pk < 100) begin
                    @(negedge clk);
                    pk++;
                end
                if (!no_drop) begin
                    repeat ($urandom_range(1, 6)) @(negedge clk);
                    pll_lock = 1'b0;
                    repeat (lock_hold != 0 ? lock_hold : int'($urandom_range(1, 12))) @(negedge clk);
                    pll_lock = 1'b1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every ack and checks strobe shape, exclusivity and gap length.
    always @(negedge clk) begin
        sv = {tst_rst_ref, wrm_rst_ref, wrm_rst_fc_ref};
        av = {tst_ack, wrm_ack, fc_ack};
        if (rst_ref) begin
            srun   = 0;
            in_gap = 1'b0;
        end else begin
            if (sv != 3'b000) strobe_cycles++;
            if ($countones(sv) > 1) chk("strobe_onehot", $countones(sv), 1);
            if (sv != 3'b000 && prev_sv == 3'b000)
                chk("strobe_who", int'(sv), q.size() != 0 ? int'(q[0].who) : 0);
            if (sv != 3'b000)
                srun++;
            else if (srun != 0) begin
                chk("strobe_width", srun, PULSE_W);
                srun = 0;
            end
            if (av != 3'b000) begin
                acks_seen++;
                if (q.size() == 0)
                    chk("ack_unexpected", int'(av), 0);
                else begin
                    e = q.pop_front();
                    chk("ack_who", int'(av), int'(e.who));
                    chk("ack_div", int'(pll_div_cfg), int'(e.div));
                    chk("ack_tmo", int'(tmo_err), int'(exp_tmo));
                end
                gap    = 0;
                in_gap = 1'b1;
            end else if (in_gap) begin
                if (busy)
                    gap++;
                else begin
                    chk("gap_len", gap, GAP_CNT);
                    in_gap = 1'b0;
                end
            end
        end
        prev_sv = sv;
    end

    initial begin
        int n, s0, a0;
        cyc(3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_strobes", int'({tst_rst_ref, wrm_rst_ref, wrm_rst_fc_ref}), 0);
        chk("rst_acks", int'({tst_ack, wrm_ack, fc_ack}), 0);
        chk("rst_div", int'(pll_div_cfg), 4);
        chk("rst_tmo", int'(tmo_err), 0);
        rst_ref = 1'b0;

        issue(3'b001, 6'd9);
        n = 0;
        while (!wrm_rst_fc_ref && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t1_grant_latency", n, 1);
        chk("t1_div", int'(pll_div_cfg), 9);
        serve(300);

        issue(3'b111, 6'($urandom));
        serve(600);

        force_unlock = 1'b1;
        issue(3'b010, cur_div);
        s0 = strobe_cycles;
        cyc(1000);
        chk("t3_no_strobe", strobe_cycles - s0, 0);
        chk("t3_idle", int'(busy), 0);
        force_unlock = 1'b0;
        @(negedge clk);
        chk("t3_strobe_next", int'(wrm_rst_ref), 1);
        serve(300);

        for (int i = 0; i < 40; i++) begin
            cyc($urandom_range(0, 5));
            issue(3'($urandom_range(1, 7)), 6'($urandom));
            serve(600);
        end

`ifdef CTU_RELOCK_TMO_EN
        no_drop = 1'b1;
        exp_tmo = 1'b1;
        issue(3'b100, cur_div);
        n = 0;
        while (!tst_rst_ref && n < 20) begin
            @(negedge clk);
            n++;
        end
        while (tst_rst_ref && n < 40) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!tst_ack && n < 400) begin
            @(negedge clk);
            n++;
        end
        tst_req = 1'b0;
        chk("t4_tmo_latency", n, 255);
        chk("t4_tmo_err", int'(tmo_err), 1);
        serve(100);
        no_drop = 1'b0;
        issue(3'b001, 6'd21);
        serve(300);
        chk("t4_tmo_sticky", int'(tmo_err), 1);
`else
        lock_hold = 70000;
        issue(3'b010, cur_div);
        n = 0;
        while (!wrm_rst_ref && n < 20) begin
            @(negedge clk);
            n++;
        end
        while ((wrm_rst_ref || pll_locked_ref) && n < 60) begin
            @(negedge clk);
            n++;
        end
        a0 = acks_seen;
        cyc(69000);
        chk("t6_busy", int'(busy), 1);
        chk("t6_tmo_err", int'(tmo_err), 0);
        chk("t6_no_ack", acks_seen - a0, 0);
        serve(3000);
        lock_hold = 0;
        chk("t6_ack_after_lock", acks_seen - a0, 1);
`endif

        lock_hold = 300;
        issue(3'b001, 6'd17);
        n = 0;
        while (!wrm_rst_fc_ref && n < 20) begin
            @(negedge clk);
            n++;
        end
        while ((wrm_rst_fc_ref || pll_locked_ref) && n < 60) begin
            @(negedge clk);
            n++;
        end
        cyc(3);
        chk("t5_busy_pre", int'(busy), 1);
        rst_ref = 1'b1;
        fc_req  = 1'b0;
        @(negedge clk);
        chk("t5_busy", int'(busy), 0);
        chk("t5_div", int'(pll_div_cfg), 4);
        chk("t5_strobes", int'({tst_rst_ref, wrm_rst_ref, wrm_rst_fc_ref}), 0);
        chk("t5_acks", int'({tst_ack, wrm_ack, fc_ack}), 0);
        chk("t5_tmo_err", int'(tmo_err), 0);
        rst_ref = 1'b0;
        q.delete();
        cur_div = 6'd4;
        exp_tmo = 1'b0;
        a0 = acks_seen;
        cyc(400);
        chk("t5_no_ack", acks_seen - a0, 0);
        lock_hold = 0;

        issue(3'b001, 6'd33);
        serve(300);
        chk("recover_div", int'(pll_div_cfg), 33);
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
